attractor_scanner: RTL
======================

Name: attractor_scanner

Overview:
- Initiator-side companion to the gene network checkers. The fixed-point and cycle checkers only watch a trajectory that is driven from outside. This block drives the trajectories itself.
- Sweeps every initial value in a range and iterates an external combinational next-state function from each one. Uses Brent's algorithm to find the attractor.
- Reports one result per initial value over a valid/ready channel: fixed point or cycle, period, and canonical (minimum) attractor state.
- Sits between the gene network next-state logic and the result logger.

Parameters:
- INIT_FIRST, 0, first initial value of the sweep (8-bit).
- INIT_LAST, 255, last initial value of the sweep, inclusive; INIT_LAST >= INIT_FIRST.
- MAX_STEPS, 1023, SEARCH-cycle budget per initial value before timeout (10-bit).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin sweep; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the result for INIT_LAST is accepted.
- f_query  out  8  state presented to the external next-state function.
- f_next  in  8  f(f_query), combinational, same cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_init  out  8  initial value of this result.
- res_fixed  out  1  1 = fixed point (period 1).
- res_period  out  9  cycle length, 1..256; 0 on timeout.
- res_attr  out  8  minimum state on the attractor cycle; 0 on timeout.
- res_timeout  out  1  search exceeded MAX_STEPS.

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - State goes to IDLE.
  - busy, done, res_valid, res_fixed and res_timeout go to 0.
  - res_init, res_period and res_attr go to 0.
  - Reset mid-sweep abandons the sweep; no result or done is emitted.
- Internal registers: cur_init (8), tort (8), hare (8), power (10), lam (9), steps (10), walk (8), amin (8), wcnt (9).
- f_query mux: cur_init in SEED, hare in SEARCH, walk in WALK, 0 otherwise.
- IDLE: on start=1, set cur_init <= INIT_FIRST and go to SEED.
- SEED (1 cycle):
  - tort <= cur_init, hare <= f_next, power <= 1, lam <= 1, steps <= 0.
  - Go to SEARCH.
- SEARCH (one Brent iteration per cycle, compares registered values):
  - If tort == hare: set walk <= hare, amin <= hare, wcnt <= 1. Go to REPORT if lam == 1, else go to WALK.
  - Else if steps == MAX_STEPS: go to REPORT with the timeout flag set.
  - Else:
    - If power == lam: tort <= hare, power <= power << 1, lam <= 1. Otherwise lam <= lam + 1.
    - In both cases: hare <= f_next, steps <= steps + 1.
- WALK:
  - Each cycle: walk <= f_next, amin <= min(amin, f_next), wcnt <= wcnt + 1.
  - Go to REPORT on the cycle where wcnt == lam - 1; that update is included, so exactly lam - 1 cycles are spent here.
- REPORT:
  - On entry, register the outputs:
    - res_init = cur_init
    - res_period = lam, or 0 on timeout
    - res_fixed = (lam == 1) and not timeout
    - res_attr = amin, or 0 on timeout
    - res_timeout = timeout flag
  - res_valid = 1 in this state.
  - All res_* fields are held stable while res_valid=1 and res_ready=0.
  - Transfer happens when res_valid & res_ready on the same edge.
  - On transfer: if cur_init == INIT_LAST, go to DONE; else cur_init <= cur_init + 1 and go to SEED.
  - res_valid drops the cycle after transfer.
- DONE: pulse done for 1 cycle, then go to IDLE. start is ignored outside IDLE.
- Arithmetic limits:
  - cur_init increments only up to INIT_LAST, so there is no 8-bit wrap.
  - lam <= 256 and power <= 512 fit their widths.
  - The state space is 256, so Brent's algorithm needs at most about 768 SEARCH cycles; the default MAX_STEPS never times out.
- Latency per initial value: 1 (SEED) + SEARCH iterations + 1 (terminating compare) + (lam - 1) WALK cycles, then REPORT waits for res_ready (>= 1 cycle).

Test Plan:
- f = identity, full sweep, res_ready=1 → 256 results in order 0..255; each has res_fixed=1, res_period=1, res_attr=res_init; done pulses once after init 255.
- f(x) = x ^ 8'h01 → every result has res_period=2, res_fixed=0, res_attr = res_init & 8'hFE.
- f(x) = x + 1 mod 256, INIT_FIRST=INIT_LAST=200 → one result: res_period=256, res_attr=0, res_timeout=0.
- f(x) = 0 constant, init 5 → res_fixed=1, res_period=1, res_attr=0 (tail of length 1 traversed).
- MAX_STEPS=4, f = x + 1 → res_timeout=1, res_period=0, res_attr=0; sweep continues with the next init.
- Backpressure plus reset:
  - Hold res_ready=0 for 10 cycles on init 3 → res_valid stays high, fields stable, no duplicate or skipped result.
  - Assert rst during SEARCH of init 7 → next cycle busy=0, res_valid=0.
  - A fresh start then restarts the sweep at INIT_FIRST.

Source files
------------

// File: rtl/attractor_scanner.sv
// Sweeps initial values through an external next-state function and finds each
// trajectory's attractor with Brent's algorithm, reporting period and minimum state.
module attractor_scanner #(
    parameter logic [7:0] INIT_FIRST = 8'd0,
    parameter logic [7:0] INIT_LAST  = 8'd255,
    parameter logic [9:0] MAX_STEPS  = 10'd1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] f_query,
    input  logic [7:0] f_next,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_init,
    output logic       res_fixed,
    output logic [8:0] res_period,
    output logic [7:0] res_attr,
    output logic       res_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SEARCH,
        WALK,
        REPORT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] cur_init;
    logic [7:0] tort;
    logic [7:0] hare;
    logic [9:0] power;
    logic [8:0] lam;
    logic [9:0] steps;
    logic [7:0] walk;
    logic [7:0] amin;
    logic [8:0] wcnt;

    logic       meet;
    logic       last_walk;
    logic [7:0] walk_min;

    assign meet      = (tort == hare);
    assign last_walk = (wcnt == lam - 9'd1);
    assign walk_min  = (f_next < amin) ? f_next : amin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        res_valid  = 1'b0;
        f_query    = 8'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SEED;
                end
            end
            SEED: begin
                f_query    = cur_init;
                state_next = SEARCH;
            end
            SEARCH: begin
                f_query = hare;
                if (meet) begin
                    state_next = (lam == 9'd1) ? REPORT : WALK;
                end else if (steps == MAX_STEPS) begin
                    state_next = REPORT;
                end
            end
            WALK: begin
                f_query = walk;
                if (last_walk) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = (cur_init == INIT_LAST) ? DONE : SEED;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result fields are loaded only on the edge entering REPORT, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_init    <= 8'd0;
            tort        <= 8'd0;
            hare        <= 8'd0;
            power       <= 10'd0;
            lam         <= 9'd0;
            steps       <= 10'd0;
            walk        <= 8'd0;
            amin        <= 8'd0;
            wcnt        <= 9'd0;
            res_init    <= 8'd0;
            res_fixed   <= 1'b0;
            res_period  <= 9'd0;
            res_attr    <= 8'd0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_init <= INIT_FIRST;
                    end
                end
                SEED: begin
                    tort  <= cur_init;
                    hare  <= f_next;
                    power <= 10'd1;
                    lam   <= 9'd1;
                    steps <= 10'd0;
                end
                SEARCH: begin
                    if (meet) begin
                        walk <= hare;
                        amin <= hare;
                        wcnt <= 9'd1;
                        if (lam == 9'd1) begin
                            res_init    <= cur_init;
                            res_period  <= lam;
                            res_fixed   <= 1'b1;
                            res_attr    <= hare;
                            res_timeout <= 1'b0;
                        end
                    end else if (steps == MAX_STEPS) begin
                        res_init    <= cur_init;
                        res_period  <= 9'd0;
                        res_fixed   <= 1'b0;
                        res_attr    <= 8'd0;
                        res_timeout <= 1'b1;
                    end else begin
                        if (power == {1'b0, lam}) begin
                            tort  <= hare;
                            power <= power << 1;
                            lam   <= 9'd1;
                        end else begin
                            lam <= lam + 9'd1;
                        end
                        hare  <= f_next;
                        steps <= steps + 10'd1;
                    end
                end
                WALK: begin
                    walk <= f_next;
                    amin <= walk_min;
                    wcnt <= wcnt + 9'd1;
                    if (last_walk) begin
                        res_init    <= cur_init;
                        res_period  <= lam;
                        res_fixed   <= (lam == 9'd1);
                        res_attr    <= walk_min;
                        res_timeout <= 1'b0;
                    end
                end
                REPORT: begin
                    if (res_ready && (cur_init != INIT_LAST)) begin
                        cur_init <= cur_init + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
